minimig_host_bus_master: RTL

Host-side bus master for the UserIO channel of the 68000 bridge. It turns a byte-serial command stream from the host controller (SPI/UserIO byte layer) into halted-CPU word accesses on the bridge's host port (`host_cs`, `host_adr`, `host_we`, `host_bs`, `host_wdat`, `host_ack`, `host_rdat`). It also controls `cpu_halt` and streams read data back as bytes. It sits directly upstream of the bridge's host interface and downstream of the byte deserializer.

---
 rtl/minimig_host_bus_master.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/minimig_host_bus_master.sv
// Host-side bus master for the UserIO channel: decodes a byte-serial command
// stream into halted-CPU word accesses on the bridge host port.
module minimig_host_bus_master #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clk7_en_i,
    input  logic        rx_start_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        cpu_halt_o,
    output logic        host_cs_o,
    output logic [22:0] host_adr_o,
    output logic        host_we_o,
    output logic [1:0]  host_bs_o,
    output logic [15:0] host_wdat_o,
    input  logic        host_ack_i,
    input  logic [15:0] host_rdat_i,
    output logic        error_o
);

    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_CMD, S_A2, S_A1, S_A0, S_WH, S_WL, S_CNT,
        S_BUS, S_REL, S_TXH, S_TXL, S_SKIP
    } state_e;

    state_e        state_q, state_d, cur_s;
    logic [22:0]   adr_q, adr_d;
    logic [15:0]   atmp_q, atmp_d;
    logic [15:0]   wdat_q, wdat_d;
    logic [15:0]   rdat_q, rdat_d;
    logic [8:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    txd_q, txd_d;
    logic [1:0]    bs_q, bs_d;
    logic          we_q, we_d, cs_q, cs_d, halt_q, halt_d, err_q, err_d;
    logic          txv_q, txv_d, ack_seen_q, ack_seen_d, abort_q, abort_d;
    logic          rdy_s, drop_s, start_s, start_we_s;

    assign rdy_s  = !((state_q == S_BUS) || (state_q == S_REL) ||
                      (state_q == S_TXH) || (state_q == S_TXL));
    assign drop_s = rx_valid_i && !rx_start_i && !rdy_s;

    // Next-state and datapath decode for the command/bus sequencer.
    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        atmp_d     = atmp_q;
        wdat_d     = wdat_q;
        rdat_d     = rdat_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        txd_d      = txd_q;
        bs_d       = bs_q;
        we_d       = we_q;
        cs_d       = cs_q;
        halt_d     = halt_q;
        ack_seen_d = ack_seen_q;
        abort_d    = abort_q;
        err_d      = (err_q && !rx_start_i) || drop_s;
        txv_d      = txv_q && !rx_start_i;
        start_s    = 1'b0;
        start_we_s = 1'b0;

        // A frame start lets an in-flight bus cycle finish before returning to CMD.
        if (rx_start_i && ((state_q == S_BUS) || (state_q == S_REL))) begin
            abort_d = 1'b1;
            cur_s   = state_q;
        end else if (rx_start_i) begin
            cur_s = S_CMD;
        end else begin
            cur_s = state_q;
        end

        case (cur_s)
            S_CMD: if (rx_valid_i) begin
                case (rx_data_i)
                    8'h01:   state_d = S_A2;
                    8'h02:   if (halt_q) state_d = S_WH;  else begin err_d = 1'b1; state_d = S_SKIP; end
                    8'h03:   if (halt_q) state_d = S_CNT; else begin err_d = 1'b1; state_d = S_SKIP; end
                    8'h04:   begin halt_d = 1'b1; state_d = S_CMD; end
                    8'h05:   begin halt_d = 1'b0; state_d = S_CMD; end
                    default: begin err_d = 1'b1; state_d = S_SKIP; end
                endcase
            end else begin
                state_d = S_CMD;
            end
            S_A2: if (rx_valid_i) begin atmp_d[15:8] = rx_data_i; state_d = S_A1; end else state_d = S_A2;
            S_A1: if (rx_valid_i) begin atmp_d[7:0]  = rx_data_i; state_d = S_A0; end else state_d = S_A1;
            S_A0: if (rx_valid_i) begin adr_d = {atmp_q, rx_data_i[7:1]}; state_d = S_CMD; end else state_d = S_A0;
            S_WH: if (rx_valid_i) begin wdat_d[15:8] = rx_data_i; state_d = S_WL; end else state_d = S_WH;
            S_WL: if (rx_valid_i) begin
                wdat_d[7:0] = rx_data_i;
                start_s     = 1'b1;
                start_we_s  = 1'b1;
            end else begin
                state_d = S_WL;
            end
            S_CNT: if (rx_valid_i) begin
                cnt_d   = {(rx_data_i == 8'h00), rx_data_i};
                start_s = 1'b1;
            end else begin
                state_d = S_CNT;
            end
            S_BUS: begin
                if (!ack_seen_q) begin
                    if (host_ack_i) begin
                        ack_seen_d = 1'b1;
                    end else if (tmo_q == TMO_LAST) begin
                        cs_d    = 1'b0;
                        bs_d    = 2'b00;
                        err_d   = 1'b1;
                        abort_d = 1'b0;
                        state_d = (abort_q || rx_start_i) ? S_CMD : S_SKIP;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end else if (clk7_en_i) begin
                    cs_d    = 1'b0;
                    bs_d    = 2'b00;
                    adr_d   = adr_q + 23'd1;
                    rdat_d  = we_q ? rdat_q : host_rdat_i;
                    cnt_d   = we_q ? cnt_q : (cnt_q - 9'd1);
                    state_d = S_REL;
                end else begin
                    state_d = S_BUS;
                end
            end
            S_REL: if (!host_ack_i) begin
                if (abort_q || rx_start_i) begin
                    abort_d = 1'b0;
                    state_d = S_CMD;
                end else if (we_q) begin
                    state_d = S_WH;
                end else begin
                    txv_d   = 1'b1;
                    txd_d   = rdat_q[15:8];
                    state_d = S_TXH;
                end
            end else begin
                state_d = S_REL;
            end
            S_TXH: if (txv_q && tx_ready_i) begin
                txd_d   = rdat_q[7:0];
                state_d = S_TXL;
            end else begin
                state_d = S_TXH;
            end
            S_TXL: begin
                if (txv_q && tx_ready_i) txv_d = 1'b0; else txv_d = txv_q;
                // The next read may only start once the low byte is gone and ack has released.
                if (!txv_q || tx_ready_i) begin
                    if (cnt_q == 9'd0) state_d = S_CMD;
                    else if (!host_ack_i) start_s = 1'b1;
                    else state_d = S_TXL;
                end else begin
                    state_d = S_TXL;
                end
            end
            S_SKIP:  state_d = S_SKIP;
            default: state_d = S_CMD;
        endcase

        if (start_s) begin
            cs_d       = 1'b1;
            bs_d       = 2'b11;
            we_d       = start_we_s;
            ack_seen_d = 1'b0;
            tmo_d      = {TW{1'b0}};
            state_d    = S_BUS;
        end else begin
            cs_d = cs_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_CMD;
            adr_q      <= 23'd0;
            atmp_q     <= 16'd0;
            wdat_q     <= 16'd0;
            rdat_q     <= 16'd0;
            cnt_q      <= 9'd0;
            tmo_q      <= {TW{1'b0}};
            txd_q      <= 8'd0;
            bs_q       <= 2'b00;
            we_q       <= 1'b0;
            cs_q       <= 1'b0;
            halt_q     <= 1'b0;
            err_q      <= 1'b0;
            txv_q      <= 1'b0;
            ack_seen_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            atmp_q     <= atmp_d;
            wdat_q     <= wdat_d;
            rdat_q     <= rdat_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            txd_q      <= txd_d;
            bs_q       <= bs_d;
            we_q       <= we_d;
            cs_q       <= cs_d;
            halt_q     <= halt_d;
            err_q      <= err_d;
            txv_q      <= txv_d;
            ack_seen_q <= ack_seen_d;
            abort_q    <= abort_d;
        end
    end

    assign rx_ready_o  = rdy_s;
    assign tx_valid_o  = txv_q;
    assign tx_data_o   = txd_q;
    assign cpu_halt_o  = halt_q;
    assign host_cs_o   = cs_q;
    assign host_adr_o  = adr_q;
    assign host_we_o   = we_q;
    assign host_bs_o   = bs_q;
    assign host_wdat_o = wdat_q;
    assign error_o     = err_q;

endmodule
